// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_sequencer
// Description : Turns one CPU load/store request (byte/halfword/word) into a
//               sequence of accesses to a single-port synchronous RAM of
//               width MEM_W. Handles multi-beat accesses, read-modify-write
//               for stores narrower than a RAM beat, lane extraction with
//               sign/zero extension, and alignment errors.
// Ports       : clk, reset (async, active-high)
//               req_*  : valid/ready request (load, word_type, signed,
//                        byte address, right-aligned store data)
//               resp_* : valid/ready response (rdata, err)
//               mem_*  : RAM strobe, write enable, word address, write data,
//                        read data (valid the cycle after the read strobe)
//               busy   : sequencer is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_sequencer #(
    parameter int ADDR_W = 32,
    parameter int MEM_W  = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_load,
    input  logic [1:0]                           req_word_type,
    input  logic                                 req_signed,
    input  logic [ADDR_W-1:0]                    req_addr,
    input  logic [31:0]                          req_wdata,
    output logic                                 resp_valid,
    input  logic                                 resp_ready,
    output logic [31:0]                          resp_rdata,
    output logic                                 resp_err,
    output logic                                 mem_en,
    output logic                                 mem_we,
    output logic [ADDR_W-$clog2(MEM_W/8)-1:0]    mem_addr,
    output logic [MEM_W-1:0]                     mem_wdata,
    input  logic [MEM_W-1:0]                     mem_rdata,
    output logic                                 busy
);

    localparam int c_B     = MEM_W / 8;          // bytes per RAM beat
    localparam int c_LB    = $clog2(c_B);        // lane-offset bits
    localparam int MEM_AW  = ADDR_W - c_LB;
    localparam int c_KW    = $clog2(4 / c_B) + 1; // beat counter width
    localparam int c_SLOTS = 32 / MEM_W;         // beats held by a 32-bit buffer

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_RD   = 3'd1,
        S_LD_CAP  = 3'd2,
        S_ST_WR   = 3'd3,
        S_RMW_RD  = 3'd4,
        S_RMW_CAP = 3'd5,
        S_RMW_WR  = 3'd6,
        S_RESP    = 3'd7
    } state_t;

    state_t            r_state;
    logic              r_load;
    logic [1:0]        r_type;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [c_KW-1:0]   r_k;
    logic [31:0]       r_buf;

    logic [2:0]        w_req_size;
    logic              w_req_err;
    logic [2:0]        w_size;
    logic [c_KW-1:0]   w_nm1;
    logic              w_last;
    logic [1:0]        w_lane;
    logic [MEM_AW-1:0] w_base;
    logic [31:0]       w_sh;
    logic [31:0]       w_ext;
    logic [MEM_W-1:0]  w_st_beat;
    logic [MEM_W-1:0]  w_merged;

    function automatic logic [2:0] size_of(input logic [1:0] t);
        case (t)
            2'b10:   return 3'd4;
            2'b01:   return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    assign w_req_size = size_of(req_word_type);
    assign w_req_err  = (req_word_type == 2'b11)
                      || ((req_word_type == 2'b10) && (req_addr[1:0] != 2'b00))
                      || ((req_word_type == 2'b01) && req_addr[0]);
    assign w_size     = size_of(r_type);

    // Index of the final beat for the latched access size.
    always_comb begin
        w_nm1 = '0;
        case (r_type)
            2'b10:   w_nm1 = c_KW'(4 / c_B - 1);
            2'b01:   w_nm1 = c_KW'((c_B == 1) ? 1 : 0);
            default: w_nm1 = '0;
        endcase
    end
    assign w_last = (r_k == w_nm1);

    generate
        if (c_LB > 0) begin : g_lane
            assign w_lane = 2'(r_addr[c_LB-1:0]);
        end else begin : g_no_lane
            assign w_lane = 2'b00;
        end
    endgenerate

    assign w_base = r_addr[ADDR_W-1:c_LB];

    // Aligned accesses of S >= B always have lane 0, so one shift serves
    // both the sub-beat and the multi-beat load cases.
    assign w_sh = r_buf >> {w_lane, 3'b000};

    always_comb begin
        w_ext = w_sh;
        case (r_type)
            2'b00:   w_ext = {{24{r_signed & w_sh[7]}},  w_sh[7:0]};
            2'b01:   w_ext = {{16{r_signed & w_sh[15]}}, w_sh[15:0]};
            default: w_ext = w_sh;
        endcase
    end

    // Store beat k of a full-beat store.
    always_comb begin
        w_st_beat = '0;
        for (int i = 0; i < c_SLOTS; i++) begin
            if (r_k == c_KW'(i)) begin
                w_st_beat = r_wdata[i*MEM_W +: MEM_W];
            end
        end
    end

    // Read-modify-write merge: bytes L..L+S-1 of the captured beat take the
    // low S store bytes, the rest keep their RAM contents.
    always_comb begin
        w_merged = r_buf[MEM_W-1:0];
        for (int j = 0; j < c_B; j++) begin
            for (int s = 0; s < 4; s++) begin
                if ((int'(w_lane) + s == j) && (s < int'(w_size))) begin
                    w_merged[j*8 +: 8] = r_wdata[s*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_load   <= 1'b0;
            r_type   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_k      <= '0;
            r_buf    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_load   <= req_load;
                        r_type   <= req_word_type;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_err    <= w_req_err;
                        r_k      <= '0;
                        if (w_req_err)                     r_state <= S_RESP;
                        else if (req_load)                 r_state <= S_LD_RD;
                        else if (int'(w_req_size) < c_B)   r_state <= S_RMW_RD;
                        else                               r_state <= S_ST_WR;
                    end
                end
                S_LD_RD:  r_state <= S_LD_CAP;
                S_LD_CAP: begin
                    for (int i = 0; i < c_SLOTS; i++) begin
                        if (r_k == c_KW'(i)) begin
                            r_buf[i*MEM_W +: MEM_W] <= mem_rdata;
                        end
                    end
                    if (w_last) begin
                        r_state <= S_RESP;
                    end else begin
                        r_k     <= r_k + c_KW'(1);
                        r_state <= S_LD_RD;
                    end
                end
                S_ST_WR: begin
                    if (w_last) r_state <= S_RESP;
                    else        r_k     <= r_k + c_KW'(1);
                end
                S_RMW_RD:  r_state <= S_RMW_CAP;
                S_RMW_CAP: begin
                    r_buf[MEM_W-1:0] <= mem_rdata;
                    r_state          <= S_RMW_WR;
                end
                S_RMW_WR:  r_state <= S_RESP;
                S_RESP: begin
                    if (resp_ready) r_state <= S_IDLE;
                end
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Moore decode from registered state: an async reset drops the strobes
    // immediately.
    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = (r_state == S_RESP) && r_err;
    assign resp_rdata = ((r_state == S_RESP) && r_load && !r_err) ? w_ext : '0;
    assign mem_en     = (r_state == S_LD_RD) || (r_state == S_ST_WR)
                      || (r_state == S_RMW_RD) || (r_state == S_RMW_WR);
    assign mem_we     = (r_state == S_ST_WR) || (r_state == S_RMW_WR);
    assign mem_addr   = mem_en ? (w_base + MEM_AW'(r_k)) : '0;
    assign mem_wdata  = (r_state == S_ST_WR)  ? w_st_beat :
                        (r_state == S_RMW_WR) ? w_merged  : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_sequencer
// Description : Self-checking bench. The MEM_W=16 instance is driven by a
//               stimulus process that pushes hand-computed responses into a
//               scoreboard queue, checked by a separate monitor process.
//               MEM_W=8 and MEM_W=32 instances cover multi-beat and
//               wide-beat read-modify-write paths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- DUT with MEM_W=16 ----------------
    logic        d16_req_valid = 0, d16_req_ready, d16_req_load = 0, d16_req_signed = 0;
    logic [1:0]  d16_req_word_type = 0;
    logic [31:0] d16_req_addr = 0, d16_req_wdata = 0;
    logic        d16_resp_valid, d16_resp_ready = 1, d16_resp_err;
    logic [31:0] d16_resp_rdata;
    logic        d16_mem_en, d16_mem_we, d16_busy;
    logic [30:0] d16_mem_addr;
    logic [15:0] d16_mem_wdata, d16_mem_rdata = 0;

    mem_access_sequencer #(.ADDR_W(32), .MEM_W(16)) u_dut16 (
        .clk(clk), .reset(reset),
        .req_valid(d16_req_valid), .req_ready(d16_req_ready), .req_load(d16_req_load),
        .req_word_type(d16_req_word_type), .req_signed(d16_req_signed),
        .req_addr(d16_req_addr), .req_wdata(d16_req_wdata),
        .resp_valid(d16_resp_valid), .resp_ready(d16_resp_ready),
        .resp_rdata(d16_resp_rdata), .resp_err(d16_resp_err),
        .mem_en(d16_mem_en), .mem_we(d16_mem_we), .mem_addr(d16_mem_addr),
        .mem_wdata(d16_mem_wdata), .mem_rdata(d16_mem_rdata), .busy(d16_busy)
    );

    // ---------------- DUT with MEM_W=8 ----------------
    logic        d8_req_valid = 0, d8_req_ready, d8_req_load = 0, d8_req_signed = 0;
    logic [1:0]  d8_req_word_type = 0;
    logic [31:0] d8_req_addr = 0, d8_req_wdata = 0;
    logic        d8_resp_valid, d8_resp_err, d8_mem_en, d8_mem_we, d8_busy;
    logic [31:0] d8_resp_rdata, d8_mem_addr;
    logic [7:0]  d8_mem_wdata, d8_mem_rdata = 0;

    mem_access_sequencer #(.ADDR_W(32), .MEM_W(8)) u_dut8 (
        .clk(clk), .reset(reset),
        .req_valid(d8_req_valid), .req_ready(d8_req_ready), .req_load(d8_req_load),
        .req_word_type(d8_req_word_type), .req_signed(d8_req_signed),
        .req_addr(d8_req_addr), .req_wdata(d8_req_wdata),
        .resp_valid(d8_resp_valid), .resp_ready(1'b1),
        .resp_rdata(d8_resp_rdata), .resp_err(d8_resp_err),
        .mem_en(d8_mem_en), .mem_we(d8_mem_we), .mem_addr(d8_mem_addr),
        .mem_wdata(d8_mem_wdata), .mem_rdata(d8_mem_rdata), .busy(d8_busy)
    );

    // ---------------- DUT with MEM_W=32 ----------------
    logic        d32_req_valid = 0, d32_req_ready, d32_req_load = 0, d32_req_signed = 0;
    logic [1:0]  d32_req_word_type = 0;
    logic [31:0] d32_req_addr = 0, d32_req_wdata = 0;
    logic        d32_resp_valid, d32_resp_err, d32_mem_en, d32_mem_we, d32_busy;
    logic [31:0] d32_resp_rdata, d32_mem_wdata, d32_mem_rdata = 0;
    logic [29:0] d32_mem_addr;

    mem_access_sequencer #(.ADDR_W(32), .MEM_W(32)) u_dut32 (
        .clk(clk), .reset(reset),
        .req_valid(d32_req_valid), .req_ready(d32_req_ready), .req_load(d32_req_load),
        .req_word_type(d32_req_word_type), .req_signed(d32_req_signed),
        .req_addr(d32_req_addr), .req_wdata(d32_req_wdata),
        .resp_valid(d32_resp_valid), .resp_ready(1'b1),
        .resp_rdata(d32_resp_rdata), .resp_err(d32_resp_err),
        .mem_en(d32_mem_en), .mem_we(d32_mem_we), .mem_addr(d32_mem_addr),
        .mem_wdata(d32_mem_wdata), .mem_rdata(d32_mem_rdata), .busy(d32_busy)
    );

    // ---------------- RAM models with preload port and access logs ----------------
    typedef struct { int c; logic [31:0] a; logic [31:0] d; } acc_t;
    acc_t rlog16[$], wlog16[$], wlog8[$];

    logic [15:0] ram16 [256];
    logic [7:0]  ram8  [256];
    logic [31:0] ram32 [256];
    logic [1:0]  pl_sel = 0;
    logic [7:0]  pl_a = 0;
    logic [31:0] pl_d = 0;

    always @(posedge clk) begin
        if (pl_sel == 2'd1) ram16[pl_a] <= pl_d[15:0];
        else if (d16_mem_en) begin
            if (d16_mem_we) begin
                ram16[d16_mem_addr[7:0]] <= d16_mem_wdata;
                wlog16.push_back('{cyc, {1'b0, d16_mem_addr}, {16'h0, d16_mem_wdata}});
            end else begin
                d16_mem_rdata <= ram16[d16_mem_addr[7:0]];
                rlog16.push_back('{cyc, {1'b0, d16_mem_addr}, 32'h0});
            end
        end
    end

    always @(posedge clk) begin
        if (pl_sel == 2'd2) ram8[pl_a] <= pl_d[7:0];
        else if (d8_mem_en) begin
            if (d8_mem_we) begin
                ram8[d8_mem_addr[7:0]] <= d8_mem_wdata;
                wlog8.push_back('{cyc, d8_mem_addr, {24'h0, d8_mem_wdata}});
            end else begin
                d8_mem_rdata <= ram8[d8_mem_addr[7:0]];
            end
        end
    end

    always @(posedge clk) begin
        if (pl_sel == 2'd3) ram32[pl_a] <= pl_d;
        else if (d32_mem_en) begin
            if (d32_mem_we) ram32[d32_mem_addr[7:0]] <= d32_mem_wdata;
            else            d32_mem_rdata <= ram32[d32_mem_addr[7:0]];
        end
    end

    task automatic preload(input logic [1:0] sel, input logic [7:0] a, input logic [31:0] d);
        pl_sel = sel; pl_a = a; pl_d = d;
        @(posedge clk); #1;
        pl_sel = 0;
    endtask

    // ---------------- Scoreboard and monitor for the MEM_W=16 instance ----------------
    typedef struct { logic [31:0] rdata; logic err; int acc; int lat; } exp_t;
    exp_t sbq[$];
    int   hold_cnt = 0;

    initial begin : monitor
        logic        prev_rv;
        logic [31:0] held_rdata;
        logic        held_err;
        exp_t        e;
        prev_rv = 1'b0; held_rdata = '0; held_err = 1'b0;
        forever begin
            @(negedge clk);
            if (d16_resp_valid && !prev_rv) begin
                if (sbq.size() == 0) begin
                    chk("resp_unexpected", {31'b0, d16_resp_valid}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_rdata",   d16_resp_rdata, e.rdata);
                    chk("resp_err",     {31'b0, d16_resp_err}, {31'b0, e.err});
                    chk("resp_latency", cyc - e.acc + 1, e.lat);
                end
                held_rdata = d16_resp_rdata;
                held_err   = d16_resp_err;
            end else if (d16_resp_valid && hold_cnt > 0) begin
                chk("hold_err",       {31'b0, d16_resp_err}, {31'b0, held_err});
                chk("hold_rdata",     d16_resp_rdata, held_rdata);
                chk("hold_req_ready", {31'b0, d16_req_ready}, 32'd0);
                chk("hold_mem_en",    {31'b0, d16_mem_en}, 32'd0);
                hold_cnt--;
            end
            prev_rv        = d16_resp_valid;
            d16_resp_ready = (hold_cnt == 0);
        end
    end

    // Issue one request to the MEM_W=16 instance; called at posedge+1.
    task automatic issue(input logic ld, input logic [1:0] t, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic push,
                         input logic [31:0] erd, input logic eer, input int elat);
        int   acc;
        logic rdy;
        d16_req_load = ld; d16_req_word_type = t; d16_req_signed = sg;
        d16_req_addr = a;  d16_req_wdata = wd;    d16_req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            @(negedge clk); rdy = d16_req_ready;
            @(posedge clk); #1;
            if (rdy) acc = cyc;
        end
        d16_req_valid = 1'b0;
        chk("accept_timeout", {31'b0, acc < 0}, 32'd0);
        if (push) sbq.push_back('{erd, eer, acc, elat});
    endtask

    task automatic wait_done();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk); #2;
            done = (sbq.size() == 0) && !d16_busy;
        end
        chk("done_timeout", {31'b0, done}, 32'd1);
    endtask

    task automatic run8(input logic ld, input logic [1:0] t, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int acc;
        d8_req_load = ld; d8_req_word_type = t; d8_req_signed = sg;
        d8_req_addr = a;  d8_req_wdata = wd;    d8_req_valid = 1'b1;
        @(posedge clk); #1;
        d8_req_valid = 1'b0; acc = cyc; lat = -1; rd = '0; er = 1'b0;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            @(negedge clk);
            if (d8_resp_valid) begin lat = cyc - acc + 1; rd = d8_resp_rdata; er = d8_resp_err; end
        end
        @(posedge clk); #1;
    endtask

    task automatic run32(input logic ld, input logic [1:0] t, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int acc;
        d32_req_load = ld; d32_req_word_type = t; d32_req_signed = sg;
        d32_req_addr = a;  d32_req_wdata = wd;    d32_req_valid = 1'b1;
        @(posedge clk); #1;
        d32_req_valid = 1'b0; acc = cyc; lat = -1; rd = '0; er = 1'b0;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            @(negedge clk);
            if (d32_resp_valid) begin lat = cyc - acc + 1; rd = d32_resp_rdata; er = d32_resp_err; end
        end
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- Stimulus ----------------
    initial begin : stimulus
        logic [31:0] rd;
        logic        er;
        int          lat;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready",  {31'b0, d16_req_ready},  32'd1);
        chk("rst_resp_valid", {31'b0, d16_resp_valid}, 32'd0);
        chk("rst_resp_err",   {31'b0, d16_resp_err},   32'd0);
        chk("rst_mem_en_we",  {30'b0, d16_mem_en, d16_mem_we}, 32'd0);
        chk("rst_busy",       {31'b0, d16_busy},       32'd0);
        chk("rst_rdata",      d16_resp_rdata,          32'd0);
        chk("rst_mem_addr",   {1'b0, d16_mem_addr},    32'd0);
        chk("rst_mem_wdata",  {16'b0, d16_mem_wdata},  32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Signed word load over two beats
        preload(2'd1, 8'h80, 32'h5678);
        preload(2'd1, 8'h81, 32'h1234);
        rlog16.delete();
        issue(1'b1, 2'b10, 1'b1, 32'h100, 32'h0, 1'b1, 32'h12345678, 1'b0, 5);
        wait_done();
        chk("t1_nreads", rlog16.size(), 2);
        if (rlog16.size() == 2) begin
            chk("t1_rd0_addr", rlog16[0].a, 32'h80);
            chk("t1_rd1_addr", rlog16[1].a, 32'h81);
        end

        // Byte loads from the upper lane, signed and unsigned
        preload(2'd1, 8'h81, 32'h9A34);
        issue(1'b1, 2'b00, 1'b1, 32'h103, 32'h0, 1'b1, 32'hFFFFFF9A, 1'b0, 3);
        wait_done();
        issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h0, 1'b1, 32'h0000009A, 1'b0, 3);
        wait_done();

        // Byte store via read-modify-write
        preload(2'd1, 8'h80, 32'h1122);
        rlog16.delete(); wlog16.delete();
        issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h123456CC, 1'b1, 32'h0, 1'b0, 4);
        wait_done();
        chk("t3_nreads",  rlog16.size(), 1);
        chk("t3_nwrites", wlog16.size(), 1);
        if (wlog16.size() == 1) begin
            chk("t3_wr_addr", wlog16[0].a, 32'h80);
            chk("t3_wr_data", wlog16[0].d, 32'hCC22);
        end
        chk("t3_ram81_kept", {16'b0, ram16[8'h81]}, 32'h9A34);

        // Two-beat word store, load it back, signed halfword load
        wlog16.delete();
        issue(1'b0, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 3);
        wait_done();
        chk("st_nwrites", wlog16.size(), 2);
        if (wlog16.size() == 2) begin
            chk("st_wr0", {wlog16[0].a[15:0], wlog16[0].d[15:0]}, 32'h0082BEEF);
            chk("st_wr1", {wlog16[1].a[15:0], wlog16[1].d[15:0]}, 32'h0083DEAD);
            chk("st_consecutive", wlog16[1].c - wlog16[0].c, 1);
        end
        issue(1'b1, 2'b10, 1'b0, 32'h104, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 5);
        wait_done();
        issue(1'b1, 2'b01, 1'b1, 32'h102, 32'h0, 1'b1, 32'hFFFF9A34, 1'b0, 3);
        wait_done();

        // Misaligned halfword load held for 3 cycles with a pending request
        rlog16.delete(); wlog16.delete();
        hold_cnt = 3;
        issue(1'b1, 2'b01, 1'b0, 32'h101, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h0, 1'b1, 32'h0000009A, 1'b0, 3);
        wait_done();
        chk("t5_nreads", rlog16.size(), 1);
        if (rlog16.size() == 1) chk("t5_rd_addr", rlog16[0].a, 32'h81);
        chk("t5_nwrites", wlog16.size(), 0);

        // Illegal word_type and misaligned word store: no RAM traffic
        rlog16.delete(); wlog16.delete();
        issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h55, 1'b1, 32'h0, 1'b1, 1);
        wait_done();
        issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h55, 1'b1, 32'h0, 1'b1, 1);
        wait_done();
        chk("err_no_mem", rlog16.size() + wlog16.size(), 0);

        // MEM_W=8: four-beat word store and load back
        wlog8.delete();
        run8(1'b0, 2'b10, 1'b0, 32'h40, 32'h12345678, rd, er, lat);
        chk("w8_st_lat", lat, 5);
        chk("w8_st_rdata", rd, 32'h0);
        chk("w8_nwrites", wlog8.size(), 4);
        if (wlog8.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("w8_wr_addr", wlog8[k].a, 32'h40 + k);
                chk("w8_wr_data", wlog8[k].d, (32'h12345678 >> (8 * k)) & 32'hFF);
                chk("w8_wr_cycle", wlog8[k].c - wlog8[0].c, k);
            end
        end
        run8(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
        chk("w8_ld_lat", lat, 9);
        chk("w8_ld_rdata", rd, 32'h12345678);

        // MEM_W=32: halfword RMW in the upper lane and signed load back
        preload(2'd3, 8'h10, 32'h11223344);
        run32(1'b0, 2'b01, 1'b0, 32'h42, 32'h0000BEEF, rd, er, lat);
        chk("w32_st_lat", lat, 4);
        chk("w32_ram", ram32[8'h10], 32'hBEEF3344);
        run32(1'b1, 2'b01, 1'b1, 32'h42, 32'h0, rd, er, lat);
        chk("w32_ld_lat", lat, 3);
        chk("w32_ld_rdata", rd, 32'hFFFFBEEF);
        chk("w32_ld_err", {31'b0, er}, 32'd0);

        // Reset during LD_CAP of a word load
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("t6_mem_en",     {31'b0, d16_mem_en},     32'd0);
        chk("t6_busy",       {31'b0, d16_busy},       32'd0);
        chk("t6_resp_valid", {31'b0, d16_resp_valid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t6_req_ready", {31'b0, d16_req_ready}, 32'd1);
        issue(1'b1, 2'b00, 1'b0, 32'h100, 32'h0, 1'b1, 32'h00000022, 1'b0, 3);
        wait_done();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
